// File: rtl/interface_pkg.sv
// interface_pkg: shared AHB-Lite encodings and line-fill engine state.
package interface_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} trans_types_t;
  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR = 3'd1;
  localparam logic [2:0] WRAP4 = 3'd2;
  localparam logic [2:0] INCR4 = 3'd3;
  localparam logic [2:0] WRAP8 = 3'd4;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} fill_state_t;
  function automatic logic [2:0] wrap_burst(input int beats);
    return beats == 8 ? WRAP8 : WRAP4;
  endfunction
endpackage

// File: rtl/wrap_addr_gen.sv
// wrap_addr_gen: next wrapped beat address and line word index of the current address.
module wrap_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int BEATS = 4
) (
  input  logic [ADDR_W-1:0]        addr,
  output logic [ADDR_W-1:0]        next_addr,
  output logic [$clog2(BEATS)-1:0] word_idx
);
  localparam int LB = $clog2(BEATS * 4);
  assign next_addr = {addr[ADDR_W-1:LB], addr[LB-1:0] + LB'(4)};
  assign word_idx = addr[LB-1:2];
endmodule

// File: rtl/ahb_wrap_fill_master.sv
// ahb_wrap_fill_master: I-cache miss line fill over an AHB-Lite wrapping burst,
// critical word first, with early critical-word return and full-line delivery.
module ahb_wrap_fill_master
  import interface_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    miss_req,
  input  logic [ADDR_W-1:0]       miss_addr,
  output logic                    miss_ready,
  output logic [ADDR_W-1:0]       haddr,
  output logic [1:0]              htrans,
  output logic [2:0]              hburst,
  output logic [2:0]              hsize,
  output logic                    hwrite,
  input  logic                    hready,
  input  logic                    hresp,
  input  logic [DATA_W-1:0]       hrdata,
  output logic                    crit_valid,
  output logic [DATA_W-1:0]       crit_data,
  output logic                    fill_valid,
  output logic [ADDR_W-1:0]       fill_addr,
  output logic [BEATS*DATA_W-1:0] fill_data,
  output logic                    fill_err
);
  localparam int IW = $clog2(BEATS);
  localparam int LB = $clog2(BEATS * 4);
  fill_state_t state, state_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [IW-1:0] word_idx, dp_idx, addr_cnt, beat_cnt;
  logic [BEATS-1:0][DATA_W-1:0] line_buf, line_next, fill_q;
  logic data_phase, resp_err, addr_acc, cap, last_addr;
  wrap_addr_gen #(.ADDR_W(ADDR_W), .BEATS(BEATS)) u_gen (
    .addr(addr_q),
    .next_addr(addr_next),
    .word_idx(word_idx)
  );
  assign data_phase = state == S_BURST || state == S_LAST;
  assign resp_err = hresp == HRESP_ERROR;
  assign addr_acc = hready && (state == S_ADDR || (state == S_BURST && !resp_err));
  assign cap = hready && !resp_err && data_phase;
  assign last_addr = addr_cnt == IW'(BEATS - 1);
  assign haddr = addr_q;
  assign hburst = wrap_burst(BEATS);
  assign hsize = HSIZE_WORD;
  assign hwrite = 1'b0;
  assign fill_data = fill_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= S_IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = miss_req ? S_ADDR : S_IDLE;
      S_ADDR:  state_next = hready ? S_BURST : S_ADDR;
      S_BURST, S_LAST:
        state_next = resp_err ? (hready ? S_IDLE : S_ERR) :
                     !hready ? state :
                     state == S_LAST ? S_IDLE : last_addr ? S_LAST : S_BURST;
      S_ERR:   state_next = hready ? S_IDLE : S_ERR;
      default: state_next = S_IDLE;
    endcase
  end
  always_comb begin
    htrans = state == S_ADDR ? NONSEQ : state == S_BURST ? SEQ : IDLE;
    miss_ready = state == S_IDLE;
  end
  always_comb begin
    line_next = line_buf;
    line_next[dp_idx] = hrdata;
  end
  // dp_idx tracks the word slot of the beat currently in its data phase
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      addr_q <= '0;
      dp_idx <= '0;
      addr_cnt <= '0;
      beat_cnt <= '0;
      line_buf <= '0;
      crit_valid <= 1'b0;
      crit_data <= '0;
      fill_valid <= 1'b0;
      fill_q <= '0;
      fill_addr <= '0;
      fill_err <= 1'b0;
    end else begin
      crit_valid <= cap && beat_cnt == '0;
      fill_valid <= cap && state == S_LAST;
      fill_err <= hready && ((data_phase && resp_err) || state == S_ERR);
      if (miss_ready && miss_req) begin
        addr_q <= miss_addr & ~ADDR_W'(3);
        addr_cnt <= '0;
        beat_cnt <= '0;
      end
      if (addr_acc) begin
        dp_idx <= word_idx;
        addr_cnt <= addr_cnt + 1'b1;
        if (!(state == S_BURST && last_addr)) addr_q <= addr_next;
      end
      if (cap) begin
        line_buf <= line_next;
        beat_cnt <= beat_cnt + 1'b1;
        if (beat_cnt == '0) crit_data <= hrdata;
      end
      if (cap && state == S_LAST) begin
        fill_q <= line_next;
        fill_addr <= {addr_q[ADDR_W-1:LB], LB'(0)};
      end
    end
endmodule

// File: doc/ahb_wrap_fill_master.md
Name: ahb_wrap_fill_master

Overview:
AHB-Lite master-side line-fill engine for the I-cache miss path.
- Takes a single miss request (word address) from the cache controller.
- Issues a wrapping burst (WRAP4/WRAP8, critical word first) onto the AHB bus; this is the upstream feeder of transfer_handler.
- Collects the returned read beats into a line buffer in natural word order.
- Returns the critical word early, then the full line.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, bus data width; only 32 is supported (word = 4 bytes)
BEATS, 4, words per line; legal values 4 (hburst WRAP4 = 3'b010) and 8 (hburst WRAP8 = 3'b100)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
miss_req  in  1  miss request valid
miss_addr  in  ADDR_W  miss byte address; bits [1:0] ignored
miss_ready  out  1  engine idle and able to accept a request
haddr  out  ADDR_W  AHB address
htrans  out  2  AHB transfer type (TRANS_TYPES)
hburst  out  3  AHB burst type
hsize  out  3  constant 3'b010 (word)
hwrite  out  1  constant 0
hready  in  1  AHB transfer-done / wait-state indicator
hresp  in  1  0 = OKAY, 1 = ERROR
hrdata  in  DATA_W  AHB read data
crit_valid  out  1  one-cycle pulse: critical word available
crit_data  out  DATA_W  critical word; held until the next capture
fill_valid  out  1  one-cycle pulse: line complete
fill_addr  out  ADDR_W  line-aligned address of the completed line
fill_data  out  BEATS*DATA_W  line data; word i is at bits [i*32 +: 32]
fill_err  out  1  one-cycle pulse: burst aborted by ERROR

Behaviour:
- Reset values (asynchronous, active-low, applied immediately on rstn=0):
  - htrans=IDLE, haddr=0, hburst=WRAP per BEATS, hsize=3'b010, hwrite=0.
  - miss_ready=1; crit_valid, fill_valid, fill_err = 0.
  - crit_data, fill_data, fill_addr = 0.
  - State = S_IDLE, beat counters = 0.
- Reset mid-burst discards the partial line; no pulse is generated.
- States:
  - S_IDLE: miss_ready=1. On an edge with miss_req=1, latch miss_addr with [1:0] forced to 00 and go to S_ADDR.
  - S_ADDR: htrans=NONSEQ, haddr=start. On an edge with hready=1, the address is accepted; go to S_BURST.
  - S_BURST: htrans=SEQ, haddr = next wrapped address; data phase of the previous beat is active.
    - On each edge with hready=1: capture hrdata for the data-phase beat and advance the address.
    - After the last address is accepted, go to S_LAST.
  - S_LAST: htrans=IDLE, haddr holds the last address. On an edge with hready=1, capture the final beat; go to S_IDLE.
  - S_ERR: htrans=IDLE. On an edge with hready=1, pulse fill_err next cycle and go to S_IDLE.
- Wrap rule: the low log2(BEATS*4) address bits increment by 4 modulo BEATS*4; upper bits are held.
- Address advance and data capture happen only on edges where hready=1. Wait states hold haddr, htrans and all state.
- Line buffer: beat data is written to word index = beat address bits [log2(BEATS)+1:2].
  - fill_addr = start address with the low log2(BEATS*4) bits cleared.
- crit_valid: pulses in the cycle after beat 0 is captured, with crit_data = that beat.
- fill_valid: pulses in the cycle after the final capture; fill_data is stable in that cycle and holds until the next fill.
- Latency with zero wait states: accept edge E0 → NONSEQ in cycle 1 → fill_valid in cycle BEATS+2. Each wait state adds 1 cycle.
- The engine is back in S_IDLE in the fill_valid cycle, so miss_ready=1 there; a miss_req in that cycle is accepted (back-to-back fills).
- miss_req while busy: ignored (miss_ready=0).
- ERROR handling: on any data-phase edge with hresp=1 and hready=0, go to S_ERR.
  - htrans=IDLE from the next cycle; no further captures; no crit_valid or fill_valid for that beat or later beats.
  - hresp=1 with hready=1 while not in S_ERR: treated the same as the S_ERR exit (fill_err pulse, go to S_IDLE).

Decomposition:
- interface_pkg holds the shared definitions:
  - TRANS_TYPES enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - Burst constants (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4).
  - Constants HSIZE_WORD=3'b010, HRESP_OKAY=0, HRESP_ERROR=1.
  - Fill-state enum.
- Sub-module wrap_addr_gen (combinational next-address plus word-index calculation, parameterised by BEATS).

Test Plan:
1. BEATS=4, hready=1 always, miss_addr=0x0000_1008, data D0..D3 = 0xA0..0xA3.
   - Required: haddr 0x1008 (NONSEQ), 0x100C, 0x1000, 0x1004 (SEQ).
   - crit_data=0xA0.
   - fill_addr=0x1000; fill_data words [0..3] = 0xA2, 0xA3, 0xA0, 0xA1.
   - fill_valid 6 cycles after the accept edge.
2. Same request with hready=0 for 2 cycles during beat 1.
   - haddr/htrans held during the wait; no capture while hready=0; fill_valid at cycle 8.
3. BEATS=8, miss_addr=0x2014.
   - Address sequence 0x2014, 0x2018, 0x201C, 0x2000 … 0x2010; hburst=3'b100; fill_addr=0x2000.
4. hresp=1/hready=0 then hresp=1/hready=1 on beat 2.
   - htrans=IDLE the next cycle; fill_err pulses once; no fill_valid; miss_ready returns to 1.
5. rstn pulled low mid-burst (after 2 beats).
   - All outputs take reset values immediately.
   - A new miss after reset completes normally with no stale words in fill_data.
6. miss_req held high continuously.
   - Second request accepted in the fill_valid cycle; its NONSEQ appears in the next cycle.
